sd_fifo_arb: RTL and testbench

Round-robin arbiter that shares one downstream sd-style consumer among several upstream tail-write FIFOs. It grants one requester at a time for a bounded burst and forwards its data through a single registered output stage. It sits between a bank of per-source input FIFOs, each of which exports `usage`, and a shared pipeline stage, and sequences which FIFO drains. Optionally, FIFOs near full receive urgent priority.

---
 rtl/sd_fifo_arb_pkg.sv | 9 +
 rtl/sd_rr_pick.sv | 37 +++
 rtl/sd_fifo_arb.sv | 136 +++++++++++++
 tb/tb_sd_fifo_arb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sd_fifo_arb_pkg.sv
// sd_fifo_arb_pkg: types shared by the FIFO arbiter and its round-robin picker.
package sd_fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/sd_rr_pick.sv
// sd_rr_pick: combinational round-robin picker. The search starts at ptr+1 and
// wraps modulo inputs, so the previous winner has the lowest priority.
module sd_rr_pick #(
  parameter int inputs = 4,
  localparam int IW = $clog2(inputs)
) (
  input  logic [inputs-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [inputs-1:0] win_oh,
  output logic [IW-1:0]     win_idx,
  output logic              any
);

  localparam logic [IW:0] N = (IW+1)'(inputs);

  logic [IW:0] cand;
  logic        found;

  // scan candidates in priority order and keep the first requester seen
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < inputs; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i + 1);
      if (cand >= N) cand = cand - N;
      if (!found && req[cand[IW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
    win_oh[win_idx] = found;
    any             = found;
  end

endmodule

// File: rtl/sd_fifo_arb.sv
// sd_fifo_arb: round-robin arbiter draining several input FIFOs into one
// registered sd-style output stage, one bounded burst per grant.
// Optional feature: define SD_FIFO_ARB_WATERMARK_EN to give requesters whose
// usage is at or above hi_wm urgent priority during arbitration.
//
//   state | meaning
//   IDLE  | no grant; arbitrate among requesters this cycle
//   HOLD  | grant[rr_ptr] may transfer until burst limit or its srdy drops
module sd_fifo_arb
  import sd_fifo_arb_pkg::*;
#(
  parameter int inputs    = 4,
  parameter int width     = 8,
  parameter int usz       = 5,
  parameter int max_burst = 4,
  parameter int hi_wm     = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [inputs-1:0]                 c_srdy,
  output logic [inputs-1:0]                 c_drdy,
  input  logic [inputs-1:0][width-1:0]      c_data,
  input  logic [inputs-1:0][usz-1:0]        c_usage,
  output logic                              p_srdy,
  input  logic                              p_drdy,
  output logic [width-1:0]                  p_data,
  output logic [$clog2(inputs)-1:0]         p_src,
  output logic                              busy
);

  localparam int IW = $clog2(inputs);
  localparam int BW = $clog2(max_burst + 1);
  localparam logic [usz-1:0] HI_WM     = usz'(hi_wm);
  localparam logic [BW-1:0]  LAST_BEAT = BW'(max_burst - 1);

  arb_state_t        state, next_state;
  logic [inputs-1:0] grant;
  logic [IW-1:0]     rr_ptr;
  logic [BW-1:0]     bcnt;

  logic [inputs-1:0] req_mask;
  logic [inputs-1:0] win_oh;
  logic [IW-1:0]     win_idx;
  logic              win_any;
  logic              xfer;
  logic              release_hold;

`ifdef SD_FIFO_ARB_WATERMARK_EN
  logic [inputs-1:0] urgent;

  // requesters whose FIFO is near full take precedence over the rest
  always_comb begin
    urgent = '0;
    for (int i = 0; i < inputs; i++)
      urgent[i] = c_srdy[i] & (c_usage[i] >= HI_WM);
  end

  assign req_mask = (|urgent) ? urgent : c_srdy;
`else
  logic unused_usage;
  assign unused_usage = ^{c_usage, HI_WM};
  assign req_mask     = c_srdy;
`endif

  sd_rr_pick #(.inputs(inputs)) u_pick (
    .req     (req_mask),
    .ptr     (rr_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  // rr_ptr always holds the granted index while in HOLD
  assign xfer         = c_srdy[rr_ptr] & c_drdy[rr_ptr];
  assign release_hold = ~c_srdy[rr_ptr] | (xfer & (bcnt == LAST_BEAT));

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // next-state: grant on any request, release on burst end or source empty
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_any)      next_state = HOLD;
      HOLD:    if (release_hold) next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // outputs: accept only for the granted port when the output stage can take a word
  always_comb begin
    c_drdy = '0;
    busy   = 1'b0;
    if (state == HOLD) begin
      busy   = 1'b1;
      c_drdy = grant & {inputs{~p_srdy | p_drdy}};
    end
  end

  // grant, round-robin pointer and burst counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant  <= '0;
      rr_ptr <= IW'(inputs - 1);
      bcnt   <= '0;
    end else if (state == IDLE) begin
      if (win_any) begin
        grant  <= win_oh;
        rr_ptr <= win_idx;
        bcnt   <= '0;
      end
    end else begin
      if (xfer)         bcnt  <= bcnt + BW'(1);
      if (release_hold) grant <= '0;
    end
  end

  // single-word output register; a drain and a load in one cycle keeps it full
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_srdy <= 1'b0;
      p_data <= '0;
      p_src  <= '0;
    end else if (xfer) begin
      p_srdy <= 1'b1;
      p_data <= c_data[rr_ptr];
      p_src  <= rr_ptr;
    end else if (p_drdy) begin
      p_srdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sd_fifo_arb.sv
// tb_sd_fifo_arb: directed bench for sd_fifo_arb (default parameters plus a
// max_burst=1 instance). Sources emit words {port, sequence} and advance on
// each accepted handshake.
module tb_sd_fifo_arb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]      c_srdy, c_drdy;
  logic [3:0][7:0] c_data;
  logic [3:0][4:0] c_usage;
  logic            p_srdy, p_drdy, busy;
  logic [7:0]      p_data;
  logic [1:0]      p_src;

  logic [3:0]      c_srdy1, c_drdy1;
  logic [3:0][7:0] c_data1;
  logic [3:0][4:0] c_usage1;
  logic            p_srdy1, p_drdy1, busy1;
  logic [7:0]      p_data1;
  logic [1:0]      p_src1;

  int checks = 0;
  int errors = 0;
  int cnt[4];

  sd_fifo_arb dut (
    .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy),
    .c_data(c_data), .c_usage(c_usage), .p_srdy(p_srdy), .p_drdy(p_drdy),
    .p_data(p_data), .p_src(p_src), .busy(busy)
  );

  sd_fifo_arb #(.max_burst(1)) dut1 (
    .clk(clk), .reset(reset), .c_srdy(c_srdy1), .c_drdy(c_drdy1),
    .c_data(c_data1), .c_usage(c_usage1), .p_srdy(p_srdy1), .p_drdy(p_drdy1),
    .p_data(p_data1), .p_src(p_src1), .busy(busy1)
  );

  task automatic set_data();
    for (int i = 0; i < 4; i++) c_data[i] = {2'(i), 6'(cnt[i])};
  endtask

  task automatic clear_cnt();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    set_data();
  endtask

  // one clock: capture handshakes at negedge, advance sources just after posedge
  task automatic tick();
    logic [3:0] hs;
    @(negedge clk);
    hs = c_srdy & c_drdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) cnt[i]++;
    set_data();
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL reset_p_srdy: got %b expected 0", p_srdy); end
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h expected 00", p_data); end
    checks++; if (p_src !== 2'd0) begin errors++; $display("FAIL reset_p_src: got %0d expected 0", p_src); end
    checks++; if (c_drdy !== 4'b0000) begin errors++; $display("FAIL reset_c_drdy: got %b expected 0000", c_drdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (p_srdy1 !== 1'b0) begin errors++; $display("FAIL reset_p_srdy1: got %b expected 0", p_srdy1); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_watermark();
    int first, second;
    logic [3:0] exp_oh;
    logic [7:0] exp_d;
`ifdef SD_FIFO_ARB_WATERMARK_EN
    first = 3; second = 0;
`else
    first = 0; second = 1;
`endif
    clear_cnt();
    c_usage = {5'd12, 5'd3, 5'd3, 5'd3};
    c_srdy  = 4'b1011;
    p_drdy  = 1'b1;
    tick();
    exp_oh = 4'b0001 << first;
    checks++; if (c_drdy !== exp_oh) begin errors++; $display("FAIL wm_first_grant: got %b expected %b", c_drdy, exp_oh); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wm_busy: got %b expected 1", busy); end
    c_usage[3] = 5'd3;
    tick();
    exp_d = {2'(first), 6'd0};
    checks++; if (p_src !== 2'(first)) begin errors++; $display("FAIL wm_first_src: got %0d expected %0d", p_src, first); end
    checks++; if (p_data !== exp_d) begin errors++; $display("FAIL wm_first_data: got %h expected %h", p_data, exp_d); end
    tick(); tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wm_release: got busy %b expected 0", busy); end
    tick();
    exp_oh = 4'b0001 << second;
    checks++; if (c_drdy !== exp_oh) begin errors++; $display("FAIL wm_second_grant: got %b expected %b", c_drdy, exp_oh); end
    c_srdy  = 4'b0000;
    c_usage = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    clear_cnt();
    cnt[0] = 5;
    set_data();
    c_srdy = 4'b0001;
    p_drdy = 1'b0;
    tick();
    checks++; if (c_drdy !== 4'b0001) begin errors++; $display("FAIL mid_grant: got %b expected 0001", c_drdy); end
    tick();
    checks++; if (p_srdy !== 1'b1 || p_data !== 8'h05) begin errors++; $display("FAIL mid_loaded: got srdy %b data %h expected 1 05", p_srdy, p_data); end
    reset = 1'b1;
    #1;
    checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL mid_p_srdy: got %b expected 0", p_srdy); end
    checks++; if (c_drdy !== 4'b0000) begin errors++; $display("FAIL mid_c_drdy: got %b expected 0000", c_drdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL mid_p_data: got %h expected 00", p_data); end
    c_srdy = 4'b0000;
    p_drdy = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_rr();
    int order[5] = '{0, 1, 2, 3, 0};
    int base[5]  = '{0, 0, 0, 0, 4};
    logic [3:0] exp_oh;
    logic [7:0] exp_d;
    clear_cnt();
    c_srdy = 4'b1111;
    p_drdy = 1'b1;
    for (int b = 0; b < 5; b++) begin
      tick();
      exp_oh = 4'b0001 << order[b];
      checks++; if (c_drdy !== exp_oh) begin errors++; $display("FAIL rr_grant%0d: got %b expected %b", b, c_drdy, exp_oh); end
      checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got p_srdy %b expected 0", b, p_srdy); end
      for (int k = 0; k < 4; k++) begin
        tick();
        exp_d = {2'(order[b]), 6'(base[b] + k)};
        checks++; if (p_srdy !== 1'b1) begin errors++; $display("FAIL rr_srdy%0d_%0d: got %b expected 1", b, k, p_srdy); end
        checks++; if (p_src !== 2'(order[b])) begin errors++; $display("FAIL rr_src%0d_%0d: got %0d expected %0d", b, k, p_src, order[b]); end
        checks++; if (p_data !== exp_d) begin errors++; $display("FAIL rr_data%0d_%0d: got %h expected %h", b, k, p_data, exp_d); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_release%0d: got busy %b expected 0", b, busy); end
    end
    c_srdy = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_single();
    int hi = 0;
    clear_cnt();
    c_srdy = 4'b0100;
    p_drdy = 1'b1;
    tick(); hi += int'(p_srdy);
    checks++; if (c_drdy !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL single_grant: got drdy %b busy %b expected 0100 1", c_drdy, busy); end
    tick(); hi += int'(p_srdy);
    checks++; if (p_data !== 8'h80) begin errors++; $display("FAIL single_word0: got %h expected 80", p_data); end
    tick(); hi += int'(p_srdy);
    checks++; if (p_data !== 8'h81) begin errors++; $display("FAIL single_word1: got %h expected 81", p_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_held: got %b expected 1", busy); end
    c_srdy = 4'b0000;
    tick(); hi += int'(p_srdy);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
    tick(); hi += int'(p_srdy);
    tick(); hi += int'(p_srdy);
    checks++; if (hi !== 2) begin errors++; $display("FAIL single_srdy_cycles: got %0d expected 2", hi); end
  endtask

  task automatic test_stall();
    clear_cnt();
    c_srdy = 4'b0010;
    p_drdy = 1'b0;
    tick();
    checks++; if (c_drdy !== 4'b0010) begin errors++; $display("FAIL stall_grant: got %b expected 0010", c_drdy); end
    for (int s = 0; s < 5; s++) begin
      tick();
      checks++; if (p_srdy !== 1'b1 || p_data !== 8'h40 || p_src !== 2'd1) begin errors++; $display("FAIL stall_hold%0d: got srdy %b data %h src %0d expected 1 40 1", s, p_srdy, p_data, p_src); end
      checks++; if (c_drdy !== 4'b0000) begin errors++; $display("FAIL stall_drdy%0d: got %b expected 0000", s, c_drdy); end
    end
    p_drdy = 1'b1;
    #1;
    checks++; if (c_drdy !== 4'b0010) begin errors++; $display("FAIL stall_reopen: got %b expected 0010", c_drdy); end
    tick();
    checks++; if (p_srdy !== 1'b1 || p_data !== 8'h41) begin errors++; $display("FAIL stall_drain_load: got srdy %b data %h expected 1 41", p_srdy, p_data); end
    c_srdy = 4'b0000;
    tick();
    checks++; if (p_srdy !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stall_end: got srdy %b busy %b expected 0 0", p_srdy, busy); end
  endtask

  task automatic test_burst1();
    int exp;
    logic [3:0] exp_oh;
    logic [7:0] exp_d;
    c_srdy1 = 4'b0011;
    p_drdy1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp = k % 2;
      tick();
      exp_oh = 4'b0001 << exp;
      checks++; if (c_drdy1 !== exp_oh || busy1 !== 1'b1) begin errors++; $display("FAIL b1_grant%0d: got drdy %b busy %b expected %b 1", k, c_drdy1, busy1, exp_oh); end
      tick();
      exp_d = (exp == 1) ? 8'hB1 : 8'hA0;
      checks++; if (p_srdy1 !== 1'b1 || p_src1 !== 2'(exp) || p_data1 !== exp_d) begin errors++; $display("FAIL b1_xfer%0d: got srdy %b src %0d data %h expected 1 %0d %h", k, p_srdy1, p_src1, p_data1, exp, exp_d); end
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b1_release%0d: got busy %b expected 0", k, busy1); end
    end
    c_srdy1 = 4'b0000;
    tick(); tick();
  endtask

  initial begin
    c_srdy   = '0;
    p_drdy   = 1'b0;
    c_usage  = '0;
    clear_cnt();
    c_srdy1  = '0;
    p_drdy1  = 1'b0;
    c_usage1 = '0;
    c_data1  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    test_reset();
    test_watermark();
    test_reset_mid();
    test_rr();
    test_single();
    test_stall();
    test_burst1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
